// File: rtl/registros_rx.sv
// Frame receiver: locks onto an active-low frame marker, collects NUM_DATOS
// bytes from the serial stream and commits them as one parallel frame.
module registros_rx #(
  parameter int unsigned FRAME_LEN = 23,
  parameter int unsigned NUM_DATOS = 11
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_bit_inicio,
  input  logic [7:0] i_data_in,
  output logic [7:0] o_datos0,
  output logic [7:0] o_datos1,
  output logic [7:0] o_datos2,
  output logic [7:0] o_datos3,
  output logic [7:0] o_datos4,
  output logic [7:0] o_datos5,
  output logic [7:0] o_datos6,
  output logic [7:0] o_datos7,
  output logic [7:0] o_datos8,
  output logic [7:0] o_datos9,
  output logic [7:0] o_datos10,
  output logic       o_frame_valid,
  output logic       o_frame_error,
  output logic       o_locked,
  output logic [7:0] o_frame_count
);

  localparam logic [4:0] LastSlot   = 5'(FRAME_LEN - 1);
  // The last data byte arrives in this slot and is committed straight from the input.
  localparam logic [4:0] CommitSlot = 5'(NUM_DATOS);

  typedef enum logic [0:0] {StHunt, StLocked} state_e;

  state_e     r_state;
  state_e     w_state_d;
  logic [4:0] r_slot;
  logic [4:0] w_slot_d;

  logic       w_commit;
  logic       w_error;
  logic       w_capture;

  logic [7:0] r_shadow [NUM_DATOS-1];
  logic [7:0] r_datos  [NUM_DATOS];
  logic       r_frame_valid;
  logic       r_frame_error;
  logic [7:0] r_frame_count;

  // State and slot counter register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StHunt;
      r_slot  <= 5'd0;
    end else begin
      r_state <= w_state_d;
      r_slot  <= w_slot_d;
    end
  end

  // Next-state logic: any marker restarts the frame at slot 0.
  always_comb begin
    w_state_d = r_state;
    w_slot_d  = r_slot;
    unique case (r_state)
      StHunt: begin
        w_slot_d = 5'd0;
        if (!i_bit_inicio) begin
          w_state_d = StLocked;
        end
      end
      StLocked: begin
        if (!i_bit_inicio) begin
          w_slot_d = 5'd0;
        end else if (r_slot == LastSlot) begin
          w_state_d = StHunt;
          w_slot_d  = 5'd0;
        end else begin
          w_slot_d = r_slot + 5'd1;
        end
      end
      default: begin
        w_state_d = StHunt;
        w_slot_d  = 5'd0;
      end
    endcase
  end

  // Event decode: a marker in the commit slot wins over the commit.
  always_comb begin
    w_error   = 1'b0;
    w_commit  = 1'b0;
    w_capture = 1'b0;
    if (r_state == StLocked) begin
      w_error   = (!i_bit_inicio && (r_slot != LastSlot)) ||
                  ( i_bit_inicio && (r_slot == LastSlot));
      w_commit  = i_bit_inicio && (r_slot == CommitSlot);
      w_capture = i_bit_inicio && (r_slot != 5'd0) && (r_slot < CommitSlot);
    end
  end

  // Shadow capture, frame commit, status pulses and frame counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < int'(NUM_DATOS) - 1; k++) begin
        r_shadow[k] <= 8'd0;
      end
      for (int k = 0; k < int'(NUM_DATOS); k++) begin
        r_datos[k] <= 8'd0;
      end
      r_frame_valid <= 1'b0;
      r_frame_error <= 1'b0;
      r_frame_count <= 8'd0;
    end else begin
      r_frame_valid <= w_commit;
      r_frame_error <= w_error;
      for (int k = 0; k < int'(NUM_DATOS) - 1; k++) begin
        if (w_capture && (r_slot == 5'(k + 1))) begin
          r_shadow[k] <= i_data_in;
        end
      end
      if (w_commit) begin
        for (int k = 0; k < int'(NUM_DATOS) - 1; k++) begin
          r_datos[k] <= r_shadow[k];
        end
        r_datos[NUM_DATOS-1] <= i_data_in;
        r_frame_count        <= r_frame_count + 8'd1;
      end
    end
  end

  assign o_datos0      = r_datos[0];
  assign o_datos1      = r_datos[1];
  assign o_datos2      = r_datos[2];
  assign o_datos3      = r_datos[3];
  assign o_datos4      = r_datos[4];
  assign o_datos5      = r_datos[5];
  assign o_datos6      = r_datos[6];
  assign o_datos7      = r_datos[7];
  assign o_datos8      = r_datos[8];
  assign o_datos9      = r_datos[9];
  assign o_datos10     = r_datos[10];
  assign o_frame_valid = r_frame_valid;
  assign o_frame_error = r_frame_error;
  assign o_frame_count = r_frame_count;
  assign o_locked      = (r_state == StLocked);

endmodule

// File: tb/tb_registros_rx.sv
// Directed bench for registros_rx: nominal, back-to-back, framing errors,
// resets and counter wrap.
module tb_registros_rx;

  typedef logic [7:0] frame_t [11];

  localparam logic [7:0] Junk = 8'hEE;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_bit_inicio;
  logic [7:0] i_data_in;
  logic [7:0] d0, d1, d2, d3, d4, d5, d6, d7, d8, d9, d10;
  logic       o_frame_valid;
  logic       o_frame_error;
  logic       o_locked;
  logic [7:0] o_frame_count;
  logic [7:0] dat [11];

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;
  int fv_cyc   = 0;

  frame_t fa, fb2, fc, fd, fe, ff, fg;

  registros_rx dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_bit_inicio  (i_bit_inicio),
    .i_data_in     (i_data_in),
    .o_datos0      (d0),
    .o_datos1      (d1),
    .o_datos2      (d2),
    .o_datos3      (d3),
    .o_datos4      (d4),
    .o_datos5      (d5),
    .o_datos6      (d6),
    .o_datos7      (d7),
    .o_datos8      (d8),
    .o_datos9      (d9),
    .o_datos10     (d10),
    .o_frame_valid (o_frame_valid),
    .o_frame_error (o_frame_error),
    .o_locked      (o_locked),
    .o_frame_count (o_frame_count)
  );

  assign dat = '{d0, d1, d2, d3, d4, d5, d6, d7, d8, d9, d10};

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Drive one slot, then return just after the edge that consumed it.
  task automatic cyc(input logic bi, input logic [7:0] d);
    i_bit_inicio = bi;
    i_data_in    = d;
    @(posedge clk);
    #1;
  endtask

  // Drive slots 0..22 of a frame; marker low in slot 22 when end_marker is set.
  task automatic run_frame(input frame_t b, input logic end_marker,
                           output int fv_n, output int fv_s,
                           output int fe_n, output int fe_s, output int unlock_n);
    fv_n = 0; fv_s = -1; fe_n = 0; fe_s = -1; unlock_n = 0;
    for (int s = 0; s < 23; s++) begin
      cyc((s == 22 && end_marker) ? 1'b0 : 1'b1, (s >= 1 && s <= 11) ? b[s-1] : Junk);
      if (o_frame_valid) begin fv_n++; fv_s = s; fv_cyc = cyc_n; end
      if (o_frame_error) begin fe_n++; fe_s = s; end
      if (!o_locked) unlock_n++;
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    cyc(1'b0, Junk);
    cyc(1'b0, Junk);
    checks++; if (o_locked !== 1'b0) begin failures++;
      $display("FAIL reset_locked got %0b want 0", o_locked); end
    checks++; if (o_frame_valid !== 1'b0) begin failures++;
      $display("FAIL reset_fv got %0b want 0", o_frame_valid); end
    checks++; if (o_frame_error !== 1'b0) begin failures++;
      $display("FAIL reset_fe got %0b want 0", o_frame_error); end
    checks++; if (o_frame_count !== 8'd0) begin failures++;
      $display("FAIL reset_count got %0d want 0", o_frame_count); end
    for (int k = 0; k < 11; k++) begin
      checks++; if (dat[k] !== 8'd0) begin failures++;
        $display("FAIL reset_datos%0d got %0d want 0", k, dat[k]); end
    end
    i_reset = 1'b0;
    cyc(1'b1, Junk);
    checks++; if (o_locked !== 1'b0) begin failures++;
      $display("FAIL hunt_idle_locked got %0b want 0", o_locked); end
  endtask

  task automatic test_nominal();
    int fv_n, fv_s, fe_n, fe_s, un;
    cyc(1'b0, Junk);
    checks++; if (o_locked !== 1'b1) begin failures++;
      $display("FAIL nom_lock got %0b want 1", o_locked); end
    run_frame(fa, 1'b1, fv_n, fv_s, fe_n, fe_s, un);
    checks++; if (fv_n !== 1 || fv_s !== 11) begin failures++;
      $display("FAIL nom_fv got n=%0d slot=%0d want n=1 slot=11", fv_n, fv_s); end
    checks++; if (fe_n !== 0 || un !== 0) begin failures++;
      $display("FAIL nom_err got fe=%0d unlocked=%0d want 0 0", fe_n, un); end
    for (int k = 0; k < 11; k++) begin
      checks++; if (dat[k] !== fa[k]) begin failures++;
        $display("FAIL nom_datos%0d got %0d want %0d", k, dat[k], fa[k]); end
    end
    checks++; if (o_frame_count !== 8'd1) begin failures++;
      $display("FAIL nom_count got %0d want 1", o_frame_count); end
  endtask

  task automatic test_back_to_back();
    int fv_n, fv_s, fe_n, fe_s, un, prev;
    frame_t f;
    for (int i = 0; i < 3; i++) begin
      f = (i == 0) ? fa : fb2;
      prev = fv_cyc;
      run_frame(f, 1'b1, fv_n, fv_s, fe_n, fe_s, un);
      checks++; if (fv_n !== 1 || fe_n !== 0 || un !== 0) begin failures++;
        $display("FAIL b2b_frame%0d got fv=%0d fe=%0d unlocked=%0d want 1 0 0", i, fv_n, fe_n, un); end
      if (i > 0) begin
        checks++; if (fv_cyc - prev !== 23) begin failures++;
          $display("FAIL b2b_spacing%0d got %0d want 23", i, fv_cyc - prev); end
      end
      checks++; if (d3 !== ((i == 0) ? 8'd44 : 8'd99)) begin failures++;
        $display("FAIL b2b_datos3_%0d got %0d want %0d", i, d3, (i == 0) ? 44 : 99); end
    end
    checks++; if (o_frame_count !== 8'd4) begin failures++;
      $display("FAIL b2b_count got %0d want 4", o_frame_count); end
  endtask

  task automatic test_missing_marker();
    int fv_n, fv_s, fe_n, fe_s, un;
    run_frame(fc, 1'b0, fv_n, fv_s, fe_n, fe_s, un);
    checks++; if (fe_n !== 1 || fe_s !== 22) begin failures++;
      $display("FAIL miss_fe got n=%0d slot=%0d want n=1 slot=22", fe_n, fe_s); end
    checks++; if (o_locked !== 1'b0 || o_frame_valid !== 1'b0) begin failures++;
      $display("FAIL miss_state got locked=%0b fv=%0b want 0 0", o_locked, o_frame_valid); end
    cyc(1'b1, Junk);
    checks++; if (o_frame_error !== 1'b0 || o_locked !== 1'b0) begin failures++;
      $display("FAIL miss_idle got fe=%0b locked=%0b want 0 0", o_frame_error, o_locked); end
    for (int k = 0; k < 11; k++) begin
      checks++; if (dat[k] !== fc[k]) begin failures++;
        $display("FAIL miss_datos%0d got %0d want %0d", k, dat[k], fc[k]); end
    end
    cyc(1'b0, Junk);
    checks++; if (o_locked !== 1'b1) begin failures++;
      $display("FAIL miss_relock got %0b want 1", o_locked); end
    run_frame(fd, 1'b1, fv_n, fv_s, fe_n, fe_s, un);
    checks++; if (fv_n !== 1 || fv_s !== 11 || fe_n !== 0) begin failures++;
      $display("FAIL miss_next got fv=%0d slot=%0d fe=%0d want 1 11 0", fv_n, fv_s, fe_n); end
    checks++; if (d0 !== fd[0] || d10 !== fd[10] || o_frame_count !== 8'd6) begin failures++;
      $display("FAIL miss_next_data got d0=%0d d10=%0d cnt=%0d want %0d %0d 6",
               d0, d10, o_frame_count, fd[0], fd[10]); end
  endtask

  task automatic test_early_marker();
    int fv_n, fv_s, fe_n, fe_s, un;
    for (int s = 0; s < 6; s++) cyc(1'b1, (s == 0) ? Junk : fe[s-1]);
    cyc(1'b0, Junk);
    checks++; if (o_frame_error !== 1'b1 || o_frame_valid !== 1'b0 || o_locked !== 1'b1) begin
      failures++;
      $display("FAIL early6 got fe=%0b fv=%0b locked=%0b want 1 0 1",
               o_frame_error, o_frame_valid, o_locked); end
    // Marker in the commit slot: error, no commit.
    for (int s = 0; s < 11; s++) cyc(1'b1, (s == 0) ? Junk : fg[s-1]);
    cyc(1'b0, fg[10]);
    checks++; if (o_frame_error !== 1'b1 || o_frame_valid !== 1'b0) begin failures++;
      $display("FAIL early11 got fe=%0b fv=%0b want 1 0", o_frame_error, o_frame_valid); end
    checks++; if (o_frame_count !== 8'd6 || d3 !== fd[3]) begin failures++;
      $display("FAIL early11_hold got cnt=%0d d3=%0d want 6 %0d", o_frame_count, d3, fd[3]); end
    run_frame(ff, 1'b1, fv_n, fv_s, fe_n, fe_s, un);
    checks++; if (fv_n !== 1 || fv_s !== 11 || fe_n !== 0) begin failures++;
      $display("FAIL early_next got fv=%0d slot=%0d fe=%0d want 1 11 0", fv_n, fv_s, fe_n); end
    for (int k = 0; k < 11; k++) begin
      checks++; if (dat[k] !== ff[k]) begin failures++;
        $display("FAIL early_datos%0d got %0d want %0d", k, dat[k], ff[k]); end
    end
  endtask

  task automatic test_reset_mid();
    int fv_n, fv_s, fe_n, fe_s, un, pulses;
    for (int s = 0; s < 9; s++) cyc(1'b1, (s == 0) ? Junk : fa[s-1]);
    i_reset = 1'b1;
    cyc(1'b1, fa[8]);
    i_reset = 1'b0;
    checks++; if (o_locked !== 1'b0 || o_frame_count !== 8'd0 || d0 !== 8'd0) begin failures++;
      $display("FAIL rst9 got locked=%0b cnt=%0d d0=%0d want 0 0 0", o_locked, o_frame_count, d0); end
    pulses = 0;
    for (int s = 0; s < 30; s++) begin
      cyc(1'b1, fa[s % 11]);
      if (o_frame_valid || o_locked) pulses++;
    end
    checks++; if (pulses !== 0) begin failures++;
      $display("FAIL rst9_quiet got %0d want 0", pulses); end
    cyc(1'b0, Junk);
    run_frame(fb2, 1'b1, fv_n, fv_s, fe_n, fe_s, un);
    checks++; if (fv_n !== 1 || o_frame_count !== 8'd1 || d3 !== 8'd99) begin failures++;
      $display("FAIL rst9_next got fv=%0d cnt=%0d d3=%0d want 1 1 99", fv_n, o_frame_count, d3); end
    // Reset on the commit edge wins.
    for (int s = 0; s < 11; s++) cyc(1'b1, (s == 0) ? Junk : fa[s-1]);
    i_reset = 1'b1;
    cyc(1'b1, fa[10]);
    i_reset = 1'b0;
    checks++; if (o_frame_valid !== 1'b0 || o_frame_count !== 8'd0 || d10 !== 8'd0) begin
      failures++;
      $display("FAIL rst11 got fv=%0b cnt=%0d d10=%0d want 0 0 0", o_frame_valid, o_frame_count, d10); end
  endtask

  task automatic test_wrap();
    int fv_n, fv_s, fe_n, fe_s, un, bad;
    bad = 0;
    cyc(1'b0, Junk);
    for (int i = 0; i < 256; i++) begin
      run_frame(fa, 1'b1, fv_n, fv_s, fe_n, fe_s, un);
      if (fv_n != 1 || fe_n != 0 || un != 0) bad++;
      if (i == 254) begin
        checks++; if (o_frame_count !== 8'd255) begin failures++;
          $display("FAIL wrap255 got %0d want 255", o_frame_count); end
      end
    end
    checks++; if (bad !== 0) begin failures++;
      $display("FAIL wrap_frames got %0d bad want 0", bad); end
    checks++; if (o_frame_count !== 8'd0) begin failures++;
      $display("FAIL wrap256 got %0d want 0", o_frame_count); end
    run_frame(fa, 1'b1, fv_n, fv_s, fe_n, fe_s, un);
    checks++; if (o_frame_count !== 8'd1) begin failures++;
      $display("FAIL wrap257 got %0d want 1", o_frame_count); end
  endtask

  initial begin
    fa  = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66, 8'd77, 8'd88, 8'd23, 8'd40, 8'd15};
    fb2 = '{8'd11, 8'd22, 8'd33, 8'd99, 8'd55, 8'd66, 8'd77, 8'd88, 8'd23, 8'd40, 8'd15};
    fc  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd12};
    fd  = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hA9, 8'hAA};
    fe  = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58, 8'h59, 8'h5A, 8'h5B};
    ff  = '{8'hC3, 8'h3C, 8'h81, 8'h18, 8'hFF, 8'h00, 8'h7E, 8'hE7, 8'h42, 8'h24, 8'h99};
    fg  = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h90, 8'hA0, 8'hB0};
    i_reset      = 1'b1;
    i_bit_inicio = 1'b1;
    i_data_in    = Junk;
    test_reset();
    test_nominal();
    test_back_to_back();
    test_missing_marker();
    test_early_marker();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/registros_rx.md
REGISTROS_RX -- requirements
Module: registros_rx

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 23, cycles per frame, slots 0..22.
REQ-002 SHALL have parameter NUM_DATOS, default 11, data bytes per frame, carried in slots 1..11.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge; single clock domain.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port bit_inicio  input  1  active-low frame marker; low for one cycle in slot 22.
REQ-006 SHALL have port data_in  input  8  serial byte stream, one byte per slot; undefined (Z/X) outside slots 1..11.
REQ-007 SHALL have ports datos0..datos10  output  8 each  last committed frame: datosK = byte of slot K+1.
REQ-008 SHALL have port frame_valid  output  1  one-cycle pulse when datos0..datos10 update.
REQ-009 SHALL have port frame_error  output  1  one-cycle pulse on framing violation.
REQ-010 SHALL have port locked  output  1  high while the receiver tracks frame timing.
REQ-011 SHALL have port frame_count  output  8  committed-frame counter, wraps 255->0.

Function
REQ-012 SHALL implement two states, HUNT and LOCKED, plus a 5-bit slot counter (0..FRAME_LEN-1).
REQ-013 In HUNT, bit_inicio=0 SHALL move to LOCKED with slot=0 on the next cycle; locked goes high that cycle.
REQ-014 In LOCKED, slot SHALL increment by 1 each cycle.
REQ-015 In slots 1..10, data_in SHALL be captured into shadow[slot-1]; data_in outside slots 1..11 SHALL never be sampled.
REQ-016 At the slot-11 edge, datos0..datos9 SHALL load shadow[0..9] and datos10 SHALL load data_in, all on the same edge.
REQ-017 frame_valid SHALL be high for exactly the cycle following that edge (slot 12), and frame_count SHALL increment on that same edge.
REQ-018 At slot 22, bit_inicio=0 SHALL set slot=0 and keep LOCKED.
REQ-019 At slot 22, bit_inicio=1 SHALL pulse frame_error next cycle, go to HUNT and drop locked.
REQ-020 In LOCKED, bit_inicio=0 in any slot 0..21 SHALL pulse frame_error next cycle and resync with slot=0, staying LOCKED.
REQ-021 When resync happens in slots 0..11, no commit SHALL occur for that frame; shadow contents are discarded.
REQ-022 bit_inicio=0 at slot 11 SHALL take precedence over the commit: no commit and no frame_valid.
REQ-023 datos0..datos10 SHALL hold their values between commits and SHALL never change without a frame_valid pulse.
REQ-024 frame_valid and frame_error SHALL never be high in the same cycle.
REQ-025 The block SHALL be fully synchronous, with no tri-state outputs and no combinational path from inputs to outputs.

Reset
REQ-026 reset=1 SHALL force HUNT, slot=0, datos0..datos10=0, frame_valid=0, frame_error=0, locked=0, frame_count=0 on the next edge.
REQ-027 reset SHALL take priority over every other event, including a commit edge.
REQ-028 A reset asserted mid-frame SHALL discard shadow data, with no commit after release until a fresh bit_inicio low is seen.

Verification
REQ-029 Nominal frame: bit_inicio low, then slots 1..11 = 11,22,33,44,55,66,77,88,23,40,15 -> one frame_valid pulse in slot 12; datos0=11 ... datos10=15; frame_count=1; frame_error never set.
REQ-030 Continuous frames: 3 back-to-back 23-cycle frames, second frame has datos3 changed to 99 -> 3 frame_valid pulses spaced 23 cycles; datos3=99 after the 2nd pulse and stays 99; locked stays 1.
REQ-031 Missing marker: bit_inicio held 1 at slot 22 -> frame_error pulse; locked=0; datos unchanged; the next marker relocks and the following frame commits.
REQ-032 Early marker: bit_inicio=0 at slot 6 -> frame_error pulse; no frame_valid for that frame; next 11 bytes commit with slot 1 = first cycle after marker+1.
REQ-033 Reset at slot 9 -> all outputs 0 next cycle; no frame_valid until a new marker plus 11 slots; frame_count restarts at 0.
REQ-034 Wrap: 256 good frames -> frame_count returns to 0; the 257th frame gives frame_count=1.
